// File: rtl/fir_pkg.sv
// Shared types and constants for the FIR tap RAM arbiter slice.
package fir_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_ENG  = 2'd1,
    OWN_LR   = 2'd2
  } owner_t;

  localparam logic [3:0] WE_FULL = 4'hF;

  localparam int REQ_ENG = 0;
  localparam int REQ_LW  = 1;
  localparam int REQ_LR  = 2;
  localparam int NUM_REQ = 3;

endpackage

// File: rtl/fir_starve_cnt.sv
// Saturating wait counter for one AXI-Lite requester; promote is high once the
// requester has been denied LIMIT times while eligible.
module fir_starve_cnt
  import fir_pkg::*;
#(
  parameter int LIMIT = 4
) (
  input  logic axis_clk,
  input  logic axis_rst_n,
  input  logic denied,
  input  logic clear,
  input  logic freeze,
  output logic promote
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      cnt <= '0;
    end else if (freeze) begin
      cnt <= cnt;
    end else if (clear) begin
      cnt <= '0;
    end else if (denied && (cnt != CW'(LIMIT))) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign promote = (cnt == CW'(LIMIT));

endmodule

// File: rtl/fir_tap_arbiter.sv
// Single-port tap BRAM arbiter: engine reads, AXI-Lite tap writes and readback.
// Define FIR_TAP_ARB_STARVE_GUARD_EN to bound AXI-Lite starvation.
module fir_tap_arbiter
  import fir_pkg::*;
#(
  parameter int pADDR_WIDTH  = 12,
  parameter int pDATA_WIDTH  = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                   axis_clk,
  input  logic                   axis_rst_n,
  input  logic                   eng_busy,
  input  logic                   eng_req,
  input  logic [pADDR_WIDTH-1:0] eng_addr,
  output logic                   eng_gnt,
  output logic                   eng_rvalid,
  output logic [pDATA_WIDTH-1:0] eng_rdata,
  input  logic                   lw_req,
  input  logic [pADDR_WIDTH-1:0] lw_addr,
  input  logic [pDATA_WIDTH-1:0] lw_data,
  output logic                   lw_gnt,
  input  logic                   lr_req,
  input  logic [pADDR_WIDTH-1:0] lr_addr,
  output logic                   lr_gnt,
  output logic                   lr_rvalid,
  input  logic                   lr_rready,
  output logic [pDATA_WIDTH-1:0] lr_rdata,
  output logic [3:0]             tap_WE,
  output logic                   tap_EN,
  output logic [pADDR_WIDTH-1:0] tap_A,
  output logic [pDATA_WIDTH-1:0] tap_Di,
  input  logic [pDATA_WIDTH-1:0] tap_Do
);

  logic [NUM_REQ-1:0]     gnt;
  logic                   lw_elig;
  logic                   lr_elig;
  logic                   lw_promote;
  logic                   lr_promote;
  owner_t                 owner_q;
  owner_t                 owner_d;
  logic                   lr_valid_q;
  logic [pDATA_WIDTH-1:0] lr_data_q;

  // A held Lite response blocks further Lite reads unless it is being accepted now.
  assign lw_elig = lw_req & ~eng_busy;
  assign lr_elig = lr_req & ~(lr_rvalid & ~lr_rready);

`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
  fir_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_lw_starve (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .denied     (lw_elig & ~gnt[REQ_LW]),
    .clear      (gnt[REQ_LW]),
    .freeze     (eng_busy),
    .promote    (lw_promote)
  );

  fir_starve_cnt #(.LIMIT(STARVE_LIMIT)) u_lr_starve (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .denied     (lr_elig & ~gnt[REQ_LR]),
    .clear      (gnt[REQ_LR]),
    .freeze     (1'b0),
    .promote    (lr_promote)
  );
`else
  logic unused_starve_limit;
  assign unused_starve_limit = ^STARVE_LIMIT;
  assign lw_promote = 1'b0;
  assign lr_promote = 1'b0;
`endif

  always_comb begin
    gnt = '0;
    if (!axis_rst_n) begin
      gnt = '0;
    end else if (lw_promote && lw_elig) begin
      gnt[REQ_LW] = 1'b1;
    end else if (lr_promote && lr_elig) begin
      gnt[REQ_LR] = 1'b1;
    end else if (eng_req) begin
      gnt[REQ_ENG] = 1'b1;
    end else if (lw_elig) begin
      gnt[REQ_LW] = 1'b1;
    end else if (lr_elig) begin
      gnt[REQ_LR] = 1'b1;
    end
  end

  always_comb begin
    tap_EN  = 1'b0;
    tap_WE  = 4'h0;
    tap_A   = '0;
    tap_Di  = '0;
    owner_d = OWN_NONE;
    if (gnt[REQ_ENG]) begin
      tap_EN  = 1'b1;
      tap_A   = eng_addr;
      owner_d = OWN_ENG;
    end else if (gnt[REQ_LW]) begin
      tap_EN = 1'b1;
      tap_WE = WE_FULL;
      tap_A  = lw_addr;
      tap_Di = lw_data;
    end else if (gnt[REQ_LR]) begin
      tap_EN  = 1'b1;
      tap_A   = lr_addr;
      owner_d = OWN_LR;
    end
  end

  // The Lite response is visible straight from tap_Do in the return cycle and
  // held in lr_data_q afterwards until the requester accepts it.
  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      owner_q    <= OWN_NONE;
      lr_valid_q <= 1'b0;
      lr_data_q  <= '0;
    end else begin
      owner_q <= owner_d;
      if (owner_q == OWN_LR) begin
        lr_valid_q <= ~lr_rready;
        lr_data_q  <= tap_Do;
      end else if (lr_rready) begin
        lr_valid_q <= 1'b0;
      end
    end
  end

  assign eng_gnt    = gnt[REQ_ENG];
  assign lw_gnt     = gnt[REQ_LW];
  assign lr_gnt     = gnt[REQ_LR];
  assign eng_rvalid = (owner_q == OWN_ENG);
  assign eng_rdata  = eng_rvalid ? tap_Do : '0;
  assign lr_rvalid  = (owner_q == OWN_LR) | lr_valid_q;
  assign lr_rdata   = (owner_q == OWN_LR) ? tap_Do : lr_data_q;

endmodule

// File: tb/tb_fir_tap_arbiter.sv
// Bench for fir_tap_arbiter: vector table, directed corner sequences and a
// randomized run against a behavioural arbitration model; includes a BRAM model.
module tb_fir_tap_arbiter;

  localparam int STARVE = 4;

  logic        axis_clk;
  logic        axis_rst_n;
  logic        eng_busy;
  logic        eng_req;
  logic [11:0] eng_addr;
  logic        eng_gnt;
  logic        eng_rvalid;
  logic [31:0] eng_rdata;
  logic        lw_req;
  logic [11:0] lw_addr;
  logic [31:0] lw_data;
  logic        lw_gnt;
  logic        lr_req;
  logic [11:0] lr_addr;
  logic        lr_gnt;
  logic        lr_rvalid;
  logic        lr_rready;
  logic [31:0] lr_rdata;
  logic [3:0]  tap_WE;
  logic        tap_EN;
  logic [11:0] tap_A;
  logic [31:0] tap_Di;
  logic [31:0] tap_Do = '0;

  logic [31:0] bram    [0:1023];
  logic [31:0] ref_mem [0:1023];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic eng;
    logic lw;
    logic lr;
    logic busy;
    logic e_g;
    logic w_g;
    logic r_g;
  } vec_t;

  vec_t vecs [11];

  fir_tap_arbiter dut (
    .axis_clk   (axis_clk),
    .axis_rst_n (axis_rst_n),
    .eng_busy   (eng_busy),
    .eng_req    (eng_req),
    .eng_addr   (eng_addr),
    .eng_gnt    (eng_gnt),
    .eng_rvalid (eng_rvalid),
    .eng_rdata  (eng_rdata),
    .lw_req     (lw_req),
    .lw_addr    (lw_addr),
    .lw_data    (lw_data),
    .lw_gnt     (lw_gnt),
    .lr_req     (lr_req),
    .lr_addr    (lr_addr),
    .lr_gnt     (lr_gnt),
    .lr_rvalid  (lr_rvalid),
    .lr_rready  (lr_rready),
    .lr_rdata   (lr_rdata),
    .tap_WE     (tap_WE),
    .tap_EN     (tap_EN),
    .tap_A      (tap_A),
    .tap_Di     (tap_Di),
    .tap_Do     (tap_Do)
  );

  initial axis_clk = 1'b0;
  always #5 axis_clk = ~axis_clk;

  // Synchronous single-port RAM with byte enables and one-cycle read latency
  always @(posedge axis_clk) begin
    if (tap_EN) begin
      tap_Do <= bram[tap_A[11:2]];
      for (int b = 0; b < 4; b++)
        if (tap_WE[b]) bram[tap_A[11:2]][8*b +: 8] <= tap_Di[8*b +: 8];
    end
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic to_drive();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic to_sample();
    @(negedge axis_clk);
  endtask

  task automatic clear_inputs();
    eng_busy = 0; eng_req = 0; eng_addr = '0;
    lw_req = 0; lw_addr = '0; lw_data = '0;
    lr_req = 0; lr_addr = '0; lr_rready = 0;
  endtask

  task automatic do_reset();
    axis_rst_n = 0;
    clear_inputs();
    repeat (2) @(posedge axis_clk);
    #1 axis_rst_n = 1;
  endtask

  task automatic do_write(input logic [11:0] a, input logic [31:0] d);
    logic got;
    got = 0;
    lw_req = 1; lw_addr = a; lw_data = d;
    for (int c = 0; c < 20; c++) begin
      to_sample();
      if (lw_gnt) got = 1;
      to_drive();
      if (got) break;
    end
    check_output("write granted", 32'(got), 32'd1);
    lw_req = 0;
    if (got) ref_mem[a[11:2]] = d;
  endtask

  task automatic do_lr_read(input logic [11:0] a, input string name);
    logic got;
    got = 0;
    lr_rready = 1; lr_req = 1; lr_addr = a;
    for (int c = 0; c < 20; c++) begin
      to_sample();
      if (lr_gnt) got = 1;
      to_drive();
      if (got) break;
    end
    check_output({name, " grant"}, 32'(got), 32'd1);
    lr_req = 0;
    to_sample();
    check_output({name, " rvalid"}, 32'(lr_rvalid), 32'd1);
    check_output({name, " rdata"}, lr_rdata, ref_mem[a[11:2]]);
    to_drive();
  endtask

  // Expected behaviour derived from the arbitration rules, one call per cycle
  logic        m_eng_v, m_lr_v;
  logic [31:0] m_eng_d, m_lr_d;
  int          lw_wait, lr_wait;
  logic        last_e, last_w, last_r;

  task automatic apply_stimulus();
    if (!eng_req || last_e) begin
      eng_req  = ($urandom_range(0, 99) < 60);
      eng_addr = 12'($urandom_range(0, 63) * 4);
    end
    if (!lw_req || last_w) begin
      lw_req  = ($urandom_range(0, 99) < 30);
      lw_addr = 12'($urandom_range(0, 63) * 4);
      lw_data = $urandom;
    end
    if (!lr_req || last_r) begin
      lr_req  = ($urandom_range(0, 99) < 30);
      lr_addr = 12'($urandom_range(0, 63) * 4);
    end
    if ($urandom_range(0, 9) < 2) eng_busy = ~eng_busy;
    lr_rready = 1'($urandom_range(0, 1));
  endtask

  task automatic model_cycle();
    logic lw_ok, lr_ok, lw_pro, lr_pro, e_x, w_x, r_x;
    logic [11:0] a_x;
    lw_ok = lw_req && !eng_busy;
    lr_ok = lr_req && !(m_lr_v && !lr_rready);
    lw_pro = 0; lr_pro = 0;
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
    lw_pro = (lw_wait >= STARVE);
    lr_pro = (lr_wait >= STARVE);
`endif
    e_x = 0; w_x = 0; r_x = 0;
    if (lw_ok && lw_pro) w_x = 1;
    else if (lr_ok && lr_pro) r_x = 1;
    else if (eng_req) e_x = 1;
    else if (lw_ok) w_x = 1;
    else if (lr_ok) r_x = 1;
    a_x = w_x ? lw_addr : r_x ? lr_addr : e_x ? eng_addr : 12'h0;

    check_output("rand eng_gnt", 32'(eng_gnt), 32'(e_x));
    check_output("rand lw_gnt", 32'(lw_gnt), 32'(w_x));
    check_output("rand lr_gnt", 32'(lr_gnt), 32'(r_x));
    check_output("rand tap_A", 32'(tap_A), 32'(a_x));
    check_output("rand tap_WE", 32'(tap_WE), w_x ? 32'hF : 32'h0);
    check_output("rand eng_rvalid", 32'(eng_rvalid), 32'(m_eng_v));
    if (m_eng_v) check_output("rand eng_rdata", eng_rdata, m_eng_d);
    check_output("rand lr_rvalid", 32'(lr_rvalid), 32'(m_lr_v));
    if (m_lr_v) check_output("rand lr_rdata", lr_rdata, m_lr_d);

    m_eng_v = e_x;
    m_eng_d = ref_mem[eng_addr[11:2]];
    if (m_lr_v && lr_rready) m_lr_v = 0;
    if (r_x) begin
      m_lr_v = 1;
      m_lr_d = ref_mem[lr_addr[11:2]];
    end
    if (w_x) ref_mem[lw_addr[11:2]] = lw_data;
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
    if (w_x) lw_wait = 0;
    else if (lw_ok && lw_wait < STARVE) lw_wait++;
    if (r_x) lr_wait = 0;
    else if (lr_ok && lr_wait < STARVE) lr_wait++;
`endif
    last_e = e_x; last_w = w_x; last_r = r_x;
  endtask

  initial begin
    int gc;
    logic eg;
    logic e, w, r;

    for (int i = 0; i < 1024; i++) begin
      bram[i] = '0;
      ref_mem[i] = '0;
    end
    vecs[0]  = '{1, 0, 0, 0, 1, 0, 0};
    vecs[1]  = '{0, 1, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 0, 1, 0, 0, 0, 1};
    vecs[3]  = '{1, 1, 0, 0, 1, 0, 0};
    vecs[4]  = '{1, 0, 1, 0, 1, 0, 0};
    vecs[5]  = '{0, 1, 1, 0, 0, 1, 0};
    vecs[6]  = '{0, 1, 1, 1, 0, 0, 1};
    vecs[7]  = '{0, 1, 0, 1, 0, 0, 0};
    vecs[8]  = '{1, 1, 1, 1, 1, 0, 0};
    vecs[9]  = '{0, 0, 0, 0, 0, 0, 0};
    vecs[10] = '{1, 1, 1, 0, 1, 0, 0};

    // Reset state with every request asserted
    axis_rst_n = 0;
    clear_inputs();
    eng_req = 1; lw_req = 1; lr_req = 1;
    eng_addr = 12'h010; lw_addr = 12'h020; lw_data = 32'h1234; lr_addr = 12'h030;
    #12;
    check_output("reset eng_gnt", 32'(eng_gnt), 32'd0);
    check_output("reset lw_gnt", 32'(lw_gnt), 32'd0);
    check_output("reset lr_gnt", 32'(lr_gnt), 32'd0);
    check_output("reset eng_rvalid", 32'(eng_rvalid), 32'd0);
    check_output("reset lr_rvalid", 32'(lr_rvalid), 32'd0);
    check_output("reset lr_rdata", lr_rdata, 32'd0);
    check_output("reset tap_EN", 32'(tap_EN), 32'd0);
    check_output("reset tap_WE", 32'(tap_WE), 32'd0);
    check_output("reset tap_A", 32'(tap_A), 32'd0);
    check_output("reset tap_Di", tap_Di, 32'd0);
    do_reset();

    // Priority table, Lite responses always accepted
    foreach (vecs[i]) begin
      eng_req = vecs[i].eng; lw_req = vecs[i].lw; lr_req = vecs[i].lr;
      eng_busy = vecs[i].busy; lr_rready = 1;
      eng_addr = 12'h100; lw_addr = 12'h200; lr_addr = 12'h300;
      lw_data = 32'h5A5A0000 + 32'(i);
      e = vecs[i].e_g; w = vecs[i].w_g; r = vecs[i].r_g;
      to_sample();
      check_output($sformatf("vec%0d eng_gnt", i), 32'(eng_gnt), 32'(e));
      check_output($sformatf("vec%0d lw_gnt", i), 32'(lw_gnt), 32'(w));
      check_output($sformatf("vec%0d lr_gnt", i), 32'(lr_gnt), 32'(r));
      check_output($sformatf("vec%0d tap_EN", i), 32'(tap_EN), 32'(e | w | r));
      check_output($sformatf("vec%0d tap_WE", i), 32'(tap_WE), w ? 32'hF : 32'h0);
      check_output($sformatf("vec%0d tap_A", i), 32'(tap_A),
                   e ? 32'h100 : w ? 32'h200 : r ? 32'h300 : 32'h0);
      if (w) ref_mem[12'h200 >> 2] = lw_data;
      to_drive();
    end
    do_reset();

    // First tap write
    lw_req = 1; lw_addr = 12'h024; lw_data = 32'h5;
    to_sample();
    check_output("tap write lw_gnt", 32'(lw_gnt), 32'd1);
    check_output("tap write WE", 32'(tap_WE), 32'hF);
    check_output("tap write A", 32'(tap_A), 32'h024);
    check_output("tap write Di", tap_Di, 32'h5);
    to_drive();
    lw_req = 0;
    ref_mem[9] = 32'h5;

    // Lite read held by lr_rready=0, with other requesters proceeding
    lr_req = 1; lr_addr = 12'h024; lr_rready = 0;
    to_sample();
    check_output("lr hold grant", 32'(lr_gnt), 32'd1);
    to_drive();
    lr_req = 0;
    to_sample();
    check_output("lr hold valid1", 32'(lr_rvalid), 32'd1);
    check_output("lr hold data1", lr_rdata, 32'h5);
    to_drive();
    eng_req = 1; eng_addr = 12'h000; lr_req = 1;
    to_sample();
    check_output("lr hold valid2", 32'(lr_rvalid), 32'd1);
    check_output("lr hold data2", lr_rdata, 32'h5);
    check_output("lr hold eng proceeds", 32'(eng_gnt), 32'd1);
    check_output("lr hold blocked2", 32'(lr_gnt), 32'd0);
    to_drive();
    eng_req = 0;
    to_sample();
    check_output("lr hold data3", lr_rdata, 32'h5);
    check_output("lr hold blocked3", 32'(lr_gnt), 32'd0);
    to_drive();
    lr_rready = 1;
    to_sample();
    check_output("lr accept valid", 32'(lr_rvalid), 32'd1);
    check_output("lr accept regrant", 32'(lr_gnt), 32'd1);
    to_drive();
    lr_req = 0;
    to_sample();
    check_output("lr second valid", 32'(lr_rvalid), 32'd1);
    check_output("lr second data", lr_rdata, 32'h5);
    to_drive();
    lr_rready = 0;
    to_sample();
    check_output("lr drained", 32'(lr_rvalid), 32'd0);
    to_drive();

    // Engine burst over 11 taps
    for (int i = 0; i < 11; i++) do_write(12'(4 * i), 32'h1000 + 32'(3 * i));
    for (int i = 0; i < 12; i++) begin
      eng_req  = (i < 11);
      eng_addr = (i < 11) ? 12'(4 * i) : 12'h0;
      to_sample();
      if (i < 11) check_output($sformatf("burst gnt%0d", i), 32'(eng_gnt), 32'd1);
      if (i > 0) begin
        check_output($sformatf("burst rvalid%0d", i - 1), 32'(eng_rvalid), 32'd1);
        check_output($sformatf("burst rdata%0d", i - 1), eng_rdata, ref_mem[i - 1]);
      end
      to_drive();
    end
    to_sample();
    check_output("burst rvalid end", 32'(eng_rvalid), 32'd0);
    to_drive();

    // Tap write locked out while a frame is in flight
    eng_busy = 1; lw_req = 1; lw_addr = 12'h040; lw_data = 32'hABCD1234;
    to_sample();
    check_output("busy lw_gnt1", 32'(lw_gnt), 32'd0);
    check_output("busy WE1", 32'(tap_WE), 32'd0);
    to_drive();
    eng_req = 1; eng_addr = 12'h040;
    to_sample();
    check_output("busy eng_gnt", 32'(eng_gnt), 32'd1);
    check_output("busy lw_gnt2", 32'(lw_gnt), 32'd0);
    to_drive();
    eng_req = 0;
    to_sample();
    check_output("busy ram untouched", eng_rdata, ref_mem[16]);
    check_output("busy lw_gnt3", 32'(lw_gnt), 32'd0);
    to_drive();
    eng_busy = 0;
    to_sample();
    check_output("unbusy lw_gnt", 32'(lw_gnt), 32'd1);
    check_output("unbusy tap_A", 32'(tap_A), 32'h040);
    to_drive();
    lw_req = 0;
    ref_mem[16] = 32'hABCD1234;
    do_lr_read(12'h040, "unbusy readback");

    // Lite read under a continuously requesting engine
    do_reset();
    lr_rready = 1; eng_req = 1; eng_addr = 12'h008; lr_req = 1; lr_addr = 12'h024;
    gc = 0; eg = 1;
    for (int c = 1; c <= 10; c++) begin
      to_sample();
      if (lr_gnt && gc == 0) begin
        gc = c;
        eg = eng_gnt;
      end
      to_drive();
      if (gc != 0) lr_req = 0;
    end
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
    check_output("lr starve grant cycle", 32'(gc), 32'd5);
    check_output("lr starve eng preempted", 32'(eg), 32'd0);
`else
    check_output("lr starve never granted", 32'(gc), 32'd0);
`endif

    // Lite write under a continuously requesting engine
    do_reset();
    eng_req = 1; eng_addr = 12'h008; lw_req = 1; lw_addr = 12'h0C0; lw_data = 32'h77;
    gc = 0; eg = 1;
    for (int c = 1; c <= 10; c++) begin
      to_sample();
      if (lw_gnt && gc == 0) begin
        gc = c;
        eg = eng_gnt;
      end
      to_drive();
      if (gc != 0) lw_req = 0;
    end
`ifdef FIR_TAP_ARB_STARVE_GUARD_EN
    check_output("lw starve grant cycle", 32'(gc), 32'd5);
    check_output("lw starve eng preempted", 32'(eg), 32'd0);
    ref_mem[48] = 32'h77;
`else
    check_output("lw starve never granted", 32'(gc), 32'd0);
`endif
    lw_req = 0; eng_req = 0;

    // Reset while a Lite response is pending
    do_reset();
    lr_rready = 0; lr_req = 1; lr_addr = 12'h024;
    to_sample();
    check_output("rst-mid grant", 32'(lr_gnt), 32'd1);
    to_drive();
    lr_req = 0;
    to_sample();
    check_output("rst-mid pending", 32'(lr_rvalid), 32'd1);
    check_output("rst-mid pending data", lr_rdata, ref_mem[9]);
    #2 axis_rst_n = 0;
    lw_req = 1; lw_addr = 12'h024; lw_data = 32'hDEADBEEF; eng_req = 1;
    #1;
    check_output("rst-mid rvalid dropped", 32'(lr_rvalid), 32'd0);
    check_output("rst-mid lw_gnt", 32'(lw_gnt), 32'd0);
    check_output("rst-mid eng_gnt", 32'(eng_gnt), 32'd0);
    check_output("rst-mid tap_EN", 32'(tap_EN), 32'd0);
    check_output("rst-mid tap_WE", 32'(tap_WE), 32'd0);
    repeat (2) @(posedge axis_clk);
    #1;
    lw_req = 0; eng_req = 0;
    axis_rst_n = 1;
    do_lr_read(12'h024, "post-reset read");

    // Randomized traffic against the model
    do_reset();
    m_eng_v = 0; m_lr_v = 0; m_eng_d = '0; m_lr_d = '0;
    lw_wait = 0; lr_wait = 0;
    last_e = 0; last_w = 0; last_r = 0;
    for (int n = 0; n < 400; n++) begin
      apply_stimulus();
      to_sample();
      model_cycle();
      to_drive();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fir_tap_arbiter.md
# fir_tap_arbiter

Single-port BRAM arbiter that shares the FIR coefficient (tap) RAM among three requesters: the FIR compute engine (reads), the AXI-Lite write path (tap programming), and the AXI-Lite read path (tap readback). It sits between the AXI-Lite front end, the MAC datapath, and the tap BRAM port. It enforces tap-write lockout while a frame is in flight and, optionally, bounds AXI-Lite starvation.

## Interface
- pADDR_WIDTH, 12, byte address width of the BRAM port
- pDATA_WIDTH, 32, data width
- STARVE_LIMIT, 4, denied cycles before a Lite requester is promoted (guard build only)

- axis_clk  in  1  clock
- axis_rst_n  in  1  asynchronous, active-low reset
- eng_busy  in  1  frame in progress; tap writes are locked out while high
- eng_req  in  1  engine read request
- eng_addr  in  pADDR_WIDTH  engine byte address
- eng_gnt  out  1  engine granted this cycle
- eng_rvalid  out  1  engine read data valid
- eng_rdata  out  pDATA_WIDTH  engine read data
- lw_req  in  1  Lite tap-write request
- lw_addr  in  pADDR_WIDTH  write byte address
- lw_data  in  pDATA_WIDTH  write data
- lw_gnt  out  1  write accepted this cycle
- lr_req  in  1  Lite tap-read request
- lr_addr  in  pADDR_WIDTH  read byte address
- lr_gnt  out  1  read accepted this cycle
- lr_rvalid  out  1  Lite read response valid
- lr_rready  in  1  Lite read response accepted
- lr_rdata  out  pDATA_WIDTH  Lite read response data
- tap_WE  out  4  byte write enables
- tap_EN  out  1  RAM enable
- tap_A  out  pADDR_WIDTH  RAM address
- tap_Di  out  pDATA_WIDTH  RAM write data
- tap_Do  in  pDATA_WIDTH  RAM read data, one cycle after the address

## Operation
- Request rule: a requester holds req high with stable addr/data until it sees gnt. A request is dropped only after it is granted.
- Grant is combinational and one-hot. At most one grant per cycle.
- Base priority: engine > lw > lr.
- lw is eligible only when eng_busy=0.
- lr is eligible only when no Lite read response is pending (lr_rvalid=0, or lr_rvalid=1 with lr_rready=1 in the same cycle).
- RAM drive:
  - On a grant: tap_EN=1, tap_A=granted address.
  - On lw grant: tap_WE=4'hF, tap_Di=lw_data.
  - With no grant: tap_EN=0, tap_WE=0, tap_A=0, tap_Di=0.
- Owner register: records which requester was granted (NONE/ENG/LR) for the read-return cycle. Writes record NONE.
- Engine return: eng_rvalid is a one-cycle pulse in the cycle after eng_gnt. eng_rdata=tap_Do in that cycle. The engine has no backpressure.
- Lite return: in the cycle after lr_gnt, tap_Do is captured into the lr_rdata register and lr_rvalid is set. lr_rvalid holds, and lr_rdata stays stable, until lr_rready is high; it clears on that edge.
- Address handling: addresses pass through unchanged. No range checks are done here.

## Timing
- Reset values: all gnt=0, eng_rvalid=0, lr_rvalid=0, lr_rdata=0, owner=NONE, starvation counters=0. RAM outputs are 0 while reset is asserted.
- Read latency: gnt at cycle N, data at N+1.
- Write latency: RAM updated at the edge that ends the lw_gnt cycle.
- Back-to-back engine reads: one per cycle; a new read may be granted in the same cycle a previous read's data returns.
- Simultaneous eng_req and lw_req with eng_busy=0: engine wins and lw waits (subject to the guard).
- eng_busy rises while lw_req is pending: the write stalls until eng_busy falls, and no partial write occurs.
- lr_rvalid high with lr_rready=0: new lr grants are blocked and other requesters proceed.
- Reset asserted mid-transaction: pending responses are discarded, and the RAM contents are not altered.

## Configuration
- FIR_TAP_ARB_STARVE_GUARD_EN defined:
  - lw and lr each have a saturating counter that increments every cycle the requester is eligible but denied.
  - The counter clears on that requester's grant.
  - At STARVE_LIMIT, the requester is promoted above the engine; lw wins over lr if both are promoted.
  - The lw counter freezes while eng_busy=1.
  - When a promoted grant preempts the engine, the engine sees eng_gnt=0 and retries.
- FIR_TAP_ARB_STARVE_GUARD_EN undefined: strict priority, no counters, and Lite requests may wait indefinitely.

## Structure
- fir_pkg holds:
  - owner enum: OWN_NONE, OWN_ENG, OWN_LR
  - WE_FULL = 4'hF
  - requester index constants
- Sub-module fir_starve_cnt (the saturating counter with a promote output), instantiated once each for lw and lr, only under the macro.

## Test plan
- Reset, then lw_req addr 0x024, data 0x0000_0005, eng_busy=0 → lw_gnt the same cycle; tap_WE=4'hF, tap_A=0x024.
- lr_req addr 0x024 with lr_rready=0 for 3 cycles → lr_gnt at N; lr_rvalid=1 from N+1; lr_rdata=0x5 held until lr_rready, then lr_rvalid=0.
- eng_req continuous on 0x000, 0x004, …, 0x028 → 11 consecutive eng_gnt; eng_rvalid each following cycle with matching data.
- eng_busy=1 and lw_req → lw_gnt stays 0, RAM is not written; eng_busy falls → lw_gnt on the next cycle.
- Guard build, eng_req held high and lr_req asserted → lr_gnt on the 5th cycle (STARVE_LIMIT=4), eng_gnt=0 that cycle. Non-guard build → lr_gnt never asserted.
- Reset asserted during a pending lr response → lr_rvalid=0 immediately; after reset release, a new lr_req completes normally.
